// File: rtl/risc16ba_bus_ctrl.sv
// rtl/risc16ba_bus_ctrl.sv - risc16ba data-side bus controller: RAM/LED decode plus idle-slot host burst engine
module risc16ba_bus_ctrl #(
  parameter logic [15:0] LED_ADDR_LO = 16'h0200,
  parameter logic [15:0] LED_ADDR_HI = 16'h0202,
  parameter int          LEN_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      daddr,
  input  logic [15:0]      ddout,
  output logic [15:0]      ddin,
  input  logic             doe,
  input  logic             dwe0,
  input  logic             dwe1,
  output logic [15:0]      ram_addr,
  output logic [15:0]      ram_wdata,
  output logic [1:0]       ram_we,
  input  logic [15:0]      ram_rdata,
  output logic [23:0]      led,
  input  logic             hst_start,
  input  logic             hst_write,
  input  logic [15:0]      hst_addr,
  input  logic [LEN_W-1:0] hst_len,
  input  logic [15:0]      hst_wdata,
  output logic             hst_wready,
  output logic [15:0]      hst_rdata,
  output logic             hst_rvalid,
  output logic             hst_busy,
  output logic             hst_done
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_addr;
  logic [LEN_W-1:0] r_count;
  logic             r_write;
  logic [23:0]      r_led;
  logic [15:0]      r_hst_rdata;
  logic             r_hst_rvalid;
  logic             r_hst_done;

  logic w_cpu;
  logic w_slot;
  logic w_last;
  logic w_start_ok;
  logic w_start_nil;
  logic w_led_lo;
  logic w_led_hi;
  logic w_unused_bits;

  // LED registers decode on the word address so odd-byte accesses at +1 still hit
  assign w_led_lo      = (daddr[15:1] == LED_ADDR_LO[15:1]);
  assign w_led_hi      = (daddr[15:1] == LED_ADDR_HI[15:1]);
  assign w_unused_bits = daddr[0] ^ hst_addr[0];

  assign w_cpu       = doe | dwe0 | dwe1;
  assign w_slot      = (r_state == ST_BURST) && !w_cpu;
  assign w_last      = (r_count == LEN_W'(1));
  assign w_start_ok  = (r_state == ST_IDLE) && hst_start && (hst_len != '0);
  assign w_start_nil = (r_state == ST_IDLE) && hst_start && (hst_len == '0);

  always_comb begin
    ram_addr   = 16'h0000;
    ram_wdata  = 16'h0000;
    ram_we     = 2'b00;
    hst_wready = 1'b0;
    if (w_cpu) begin
      ram_addr  = daddr & 16'hFFFE;
      ram_wdata = ddout;
      ram_we    = {dwe0 & ~w_led_lo, dwe1 & ~(w_led_lo | w_led_hi)};
    end else if (w_slot) begin
      ram_addr = r_addr;
      if (r_write) begin
        ram_wdata  = hst_wdata;
        ram_we     = 2'b11;
        hst_wready = 1'b1;
      end
    end
  end

  assign ddin       = doe ? ram_rdata : 16'h0000;
  assign led        = r_led;
  assign hst_rdata  = r_hst_rdata;
  assign hst_rvalid = r_hst_rvalid;
  assign hst_done   = r_hst_done;
  assign hst_busy   = (r_state == ST_BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok)       w_state_nxt = ST_BURST;
      ST_BURST: if (w_slot && w_last) w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= 16'h0000;
      r_count      <= '0;
      r_write      <= 1'b0;
      r_led        <= 24'h000000;
      r_hst_rdata  <= 16'h0000;
      r_hst_rvalid <= 1'b0;
      r_hst_done   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_addr  <= {hst_addr[15:1], 1'b0};
        r_count <= hst_len;
        r_write <= hst_write;
      end else if (w_slot) begin
        r_addr  <= r_addr + 16'd2;
        r_count <= r_count - LEN_W'(1);
      end
      if (dwe1 && w_led_lo) r_led[7:0]   <= ddout[7:0];
      if (dwe0 && w_led_lo) r_led[15:8]  <= ddout[15:8];
      if (dwe1 && w_led_hi) r_led[23:16] <= ddout[7:0];
      r_hst_rvalid <= w_slot && !r_write;
      if (w_slot && !r_write) r_hst_rdata <= ram_rdata;
      r_hst_done <= (w_slot && w_last) || w_start_nil;
    end
  end

endmodule

// File: tb/tb_risc16ba_bus_ctrl.sv
// tb/tb_risc16ba_bus_ctrl.sv - directed self-checking bench for risc16ba_bus_ctrl
module tb_risc16ba_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] daddr = '0;
  logic [15:0] ddout = '0;
  logic [15:0] ddin;
  logic        doe = 1'b0;
  logic        dwe0 = 1'b0;
  logic        dwe1 = 1'b0;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_we;
  logic [15:0] ram_rdata;
  logic [23:0] led;
  logic        hst_start = 1'b0;
  logic        hst_write = 1'b0;
  logic [15:0] hst_addr = '0;
  logic [7:0]  hst_len = '0;
  logic [15:0] hst_wdata = '0;
  logic        hst_wready;
  logic [15:0] hst_rdata;
  logic        hst_rvalid;
  logic        hst_busy;
  logic        hst_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [0:32767];

  always #5 clk = ~clk;

  risc16ba_bus_ctrl #(.LED_ADDR_LO(16'h0200), .LED_ADDR_HI(16'h0202), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .daddr(daddr), .ddout(ddout), .ddin(ddin),
    .doe(doe), .dwe0(dwe0), .dwe1(dwe1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .led(led), .hst_start(hst_start), .hst_write(hst_write), .hst_addr(hst_addr),
    .hst_len(hst_len), .hst_wdata(hst_wdata), .hst_wready(hst_wready),
    .hst_rdata(hst_rdata), .hst_rvalid(hst_rvalid), .hst_busy(hst_busy), .hst_done(hst_done)
  );

  assign ram_rdata = mem[ram_addr[15:1]];

  always @(posedge clk) begin
    if (ram_we[1]) mem[ram_addr[15:1]][15:8] <= ram_wdata[15:8];
    if (ram_we[0]) mem[ram_addr[15:1]][7:0]  <= ram_wdata[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // advance to just after the next rising edge and drop all one-cycle strobes
  task automatic nxt();
    @(posedge clk);
    #1;
    doe = 1'b0; dwe0 = 1'b0; dwe1 = 1'b0; hst_start = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;

    #2;
    smp();
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_busy", 32'(hst_busy), 32'h0);
    chk("rst_done", 32'(hst_done), 32'h0);
    chk("rst_rvalid", 32'(hst_rvalid), 32'h0);
    chk("rst_rdata", 32'(hst_rdata), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    nxt(); rst = 1'b1;

    nxt(); daddr = 16'h0200; ddout = 16'hA55A; dwe0 = 1'b1; dwe1 = 1'b1;
    smp(); chk("led_lo_we", 32'(ram_we), 32'h0);
    nxt(); daddr = 16'h0202; ddout = 16'h00C3; dwe1 = 1'b1;
    smp(); chk("led_hi_we", 32'(ram_we), 32'h0);
    nxt();
    smp(); chk("led_val", 32'(led), 32'hC3A55A);
    chk("idle_we", 32'(ram_we), 32'h0);
    chk("idle_addr", 32'(ram_addr), 32'h0);
    nxt(); daddr = 16'h0202; ddout = 16'h7700; dwe0 = 1'b1;
    smp(); chk("led_hi_even_we", 32'(ram_we), 32'h2);
    nxt();
    smp(); chk("led_unchanged", 32'(led), 32'hC3A55A);

    nxt(); daddr = 16'h1234; ddout = 16'hBEEF; dwe0 = 1'b1; dwe1 = 1'b1;
    smp(); chk("word_we", 32'(ram_we), 32'h3);
    nxt(); daddr = 16'h1235; ddout = 16'h1234; dwe1 = 1'b1;
    smp(); chk("odd_addr", 32'(ram_addr), 32'h1234);
    chk("odd_we", 32'(ram_we), 32'h1);
    nxt(); daddr = 16'h1234; doe = 1'b1;
    smp(); chk("odd_readback", 32'(ddin), 32'hBE34);
    nxt(); daddr = 16'h1234;
    smp(); chk("ddin_no_oe", 32'(ddin), 32'h0);

    // host write burst wrapping past 0xFFFE
    nxt(); hst_start = 1'b1; hst_write = 1'b1; hst_addr = 16'hFFFD; hst_len = 8'd3; hst_wdata = 16'h1111;
    smp(); chk("wb_t_busy", 32'(hst_busy), 32'h0);
    chk("wb_t_we", 32'(ram_we), 32'h0);
    nxt(); hst_wdata = 16'h1111;
    smp(); chk("wb1_busy", 32'(hst_busy), 32'h1);
    chk("wb1_addr", 32'(ram_addr), 32'hFFFC);
    chk("wb1_we", 32'(ram_we), 32'h3);
    chk("wb1_wready", 32'(hst_wready), 32'h1);
    chk("wb1_wdata", 32'(ram_wdata), 32'h1111);
    nxt(); hst_wdata = 16'h2222;
    smp(); chk("wb2_addr", 32'(ram_addr), 32'hFFFE);
    chk("wb2_done", 32'(hst_done), 32'h0);
    nxt(); hst_wdata = 16'h3333;
    smp(); chk("wb3_addr", 32'(ram_addr), 32'h0000);
    chk("wb3_we", 32'(ram_we), 32'h3);
    nxt(); hst_wdata = 16'h4444;
    smp(); chk("wb4_done", 32'(hst_done), 32'h1);
    chk("wb4_busy", 32'(hst_busy), 32'h0);
    chk("wb4_we", 32'(ram_we), 32'h0);
    chk("wb4_wready", 32'(hst_wready), 32'h0);
    nxt(); daddr = 16'hFFFC; doe = 1'b1;
    smp(); chk("wb_rd_fffc", 32'(ddin), 32'h1111);
    chk("wb5_done", 32'(hst_done), 32'h0);
    nxt(); daddr = 16'hFFFE; doe = 1'b1;
    smp(); chk("wb_rd_fffe", 32'(ddin), 32'h2222);

    // host read burst with a CPU read stealing the first cycle
    nxt(); daddr = 16'hC000; ddout = 16'hA1A1; dwe0 = 1'b1; dwe1 = 1'b1;
    nxt(); daddr = 16'hC002; ddout = 16'hB2B2; dwe0 = 1'b1; dwe1 = 1'b1;
    nxt(); hst_start = 1'b1; hst_write = 1'b0; hst_addr = 16'hC000; hst_len = 8'd2;
    nxt(); daddr = 16'h0000; doe = 1'b1;
    smp(); chk("rb1_ddin", 32'(ddin), 32'h3333);
    chk("rb1_addr", 32'(ram_addr), 32'h0000);
    chk("rb1_busy", 32'(hst_busy), 32'h1);
    nxt();
    smp(); chk("rb2_addr", 32'(ram_addr), 32'hC000);
    chk("rb2_we", 32'(ram_we), 32'h0);
    chk("rb2_rvalid", 32'(hst_rvalid), 32'h0);
    chk("rb2_wready", 32'(hst_wready), 32'h0);
    nxt();
    smp(); chk("rb3_rvalid", 32'(hst_rvalid), 32'h1);
    chk("rb3_rdata", 32'(hst_rdata), 32'hA1A1);
    chk("rb3_addr", 32'(ram_addr), 32'hC002);
    nxt();
    smp(); chk("rb4_rvalid", 32'(hst_rvalid), 32'h1);
    chk("rb4_rdata", 32'(hst_rdata), 32'hB2B2);
    chk("rb4_done", 32'(hst_done), 32'h1);
    chk("rb4_busy", 32'(hst_busy), 32'h0);
    nxt();
    smp(); chk("rb5_rvalid", 32'(hst_rvalid), 32'h0);

    // zero-length burst
    nxt(); hst_start = 1'b1; hst_write = 1'b1; hst_addr = 16'h0400; hst_len = 8'd0;
    nxt();
    smp(); chk("z_done", 32'(hst_done), 32'h1);
    chk("z_busy", 32'(hst_busy), 32'h0);
    chk("z_we", 32'(ram_we), 32'h0);
    nxt();
    smp(); chk("z_done_clr", 32'(hst_done), 32'h0);

    // start while busy is ignored
    nxt(); hst_start = 1'b1; hst_write = 1'b1; hst_addr = 16'h0100; hst_len = 8'd2; hst_wdata = 16'h5555;
    nxt(); hst_start = 1'b1; hst_addr = 16'h0800; hst_len = 8'd5;
    smp(); chk("ig1_addr", 32'(ram_addr), 32'h0100);
    nxt();
    smp(); chk("ig2_addr", 32'(ram_addr), 32'h0102);
    nxt();
    smp(); chk("ig3_done", 32'(hst_done), 32'h1);
    chk("ig3_busy", 32'(hst_busy), 32'h0);
    nxt();
    smp(); chk("ig4_busy", 32'(hst_busy), 32'h0);
    chk("ig4_we", 32'(ram_we), 32'h0);

    // reset in the middle of a write burst
    nxt(); hst_start = 1'b1; hst_write = 1'b1; hst_addr = 16'h0300; hst_len = 8'd4; hst_wdata = 16'h6666;
    nxt();
    smp(); chk("mr_pre_we", 32'(ram_we), 32'h3);
    nxt();
    #1 rst = 1'b0;
    #1;
    chk("mr_busy", 32'(hst_busy), 32'h0);
    chk("mr_we", 32'(ram_we), 32'h0);
    chk("mr_addr", 32'(ram_addr), 32'h0);
    chk("mr_led", 32'(led), 32'h0);
    chk("mr_wready", 32'(hst_wready), 32'h0);
    nxt(); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("post_rst_we", 32'(ram_we), 32'h0);
      chk("post_rst_busy", 32'(hst_busy), 32'h0);
      nxt();
    end
    daddr = 16'h0304; doe = 1'b1;
    smp(); chk("abandoned_word", 32'(ddin), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
